bf_para_rd_sched: RTL and testbench

//  Read-side scheduler for the BF-parameter URAM buffer: SLOT_NUM frame slots filled by the PCIe writer.

---
 rtl/bf_para_pkg.sv | 15 +
 rtl/bf_para_lat_pipe.sv | 25 ++
 rtl/bf_para_rd_sched.sv | 162 ++++++++++++++++
 tb/tb_bf_para_rd_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_para_pkg.sv
// Shared definitions for the BF-parameter read scheduler: FSM encoding and default geometry.
package bf_para_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_READ  = 3'b010,
    ST_DRAIN = 3'b100
  } bf_state_t;

  localparam int BF_SLOT_NUM    = 4;
  localparam int BF_BURST_LEN   = 80;
  localparam int BF_SLOT_STRIDE = 128;
  localparam int BF_RD_LAT      = 3;

endpackage

// File: rtl/bf_para_lat_pipe.sv
// Fixed-depth shift register that aligns read-issue flags with RAM output data.
module bf_para_lat_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  logic [W-1:0] r_sh [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_sh[i] <= '0;
    end else begin
      r_sh[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) r_sh[i] <= r_sh[i-1];
    end
  end

  assign o_dat = r_sh[DEPTH-1];

endmodule

// File: rtl/bf_para_rd_sched.sv
// Read scheduler for the BF-parameter slot ring: tracks occupancy, issues gated read bursts.
// Optional BF_PARA_OVF_CNT_EN adds a saturating ovf_cnt counter of dropped frames.
module bf_para_rd_sched
  import bf_para_pkg::*;
#(
  parameter int SLOT_NUM    = BF_SLOT_NUM,
  parameter int BURST_LEN   = BF_BURST_LEN,
  parameter int SLOT_STRIDE = BF_SLOT_STRIDE,
  parameter int RADDR_W     = 17,
  parameter int RD_LAT      = BF_RD_LAT,
  parameter int INFO_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_done,
  input  logic [INFO_W-1:0]             wr_info,
  output logic [$clog2(SLOT_NUM)-1:0]   wr_slot,
  output logic                          wr_allow,
  input  logic                          bit_rrdy,
  output logic [RADDR_W-1:0]            bit_raddr,
  output logic                          ram_rden,
  output logic                          bit_rvld,
  output logic [INFO_W-1:0]             bit_rinfo,
  output logic                          bit_rlast,
  output logic [$clog2(SLOT_NUM+1)-1:0] free_size,
  output logic                          ovf_err
`ifdef BF_PARA_OVF_CNT_EN
  ,
  output logic [15:0]                   ovf_cnt
`endif
);

  localparam int SW = $clog2(SLOT_NUM);
  localparam int FW = $clog2(SLOT_NUM + 1);
  localparam int CW = $clog2(BURST_LEN);
  localparam int DW = $clog2(RD_LAT + 1);

  if (SLOT_NUM * SLOT_STRIDE > (1 << RADDR_W)) begin : g_addr_range_chk
    $error("slot ring does not fit in RADDR_W address bits");
  end

  bf_state_t          r_state, w_state_nxt;
  logic [SW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [FW-1:0]      r_free;
  logic [CW-1:0]      r_word_cnt, w_word_cnt_nxt;
  logic [DW-1:0]      r_drain_cnt, w_drain_cnt_nxt;
  logic [INFO_W-1:0]  r_info [SLOT_NUM];
  logic [INFO_W-1:0]  r_rinfo;
  logic               r_ovf_err;
  logic               w_wr_acc, w_release, w_ld_info, w_rden, w_last;
  logic [1:0]         w_pipe_out;

  assign wr_allow  = (r_free != '0);
  assign w_wr_acc  = wr_done && wr_allow;
  assign w_last    = w_rden && (r_word_cnt == CW'(BURST_LEN - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_word_cnt_nxt  = r_word_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    w_rden          = 1'b0;
    w_release       = 1'b0;
    w_ld_info       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_word_cnt_nxt = '0;
        if (r_free != FW'(SLOT_NUM)) begin
          w_state_nxt = ST_READ;
          w_ld_info   = 1'b1;
        end
      end
      ST_READ: begin
        if (bit_rrdy) begin
          w_rden = 1'b1;
          if (r_word_cnt == CW'(BURST_LEN - 1)) begin
            w_state_nxt     = ST_DRAIN;
            w_word_cnt_nxt  = '0;
            w_drain_cnt_nxt = '0;
          end else begin
            w_word_cnt_nxt = r_word_cnt + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Release in the cycle the last word is on bit_rvld, never earlier.
        if (r_drain_cnt == DW'(RD_LAT - 1)) begin
          w_state_nxt     = ST_IDLE;
          w_release       = 1'b1;
          w_drain_cnt_nxt = '0;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + DW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_free      <= FW'(SLOT_NUM);
      r_word_cnt  <= '0;
      r_drain_cnt <= '0;
      r_rinfo     <= '0;
      r_ovf_err   <= 1'b0;
      for (int i = 0; i < SLOT_NUM; i++) r_info[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      if (w_wr_acc) begin
        r_info[r_wr_ptr] <= wr_info;
        r_wr_ptr         <= r_wr_ptr + SW'(1);
      end
      if (w_release) r_rd_ptr <= r_rd_ptr + SW'(1);
      case ({w_wr_acc, w_release})
        2'b10:   r_free <= r_free - FW'(1);
        2'b01:   r_free <= r_free + FW'(1);
        default: r_free <= r_free;
      endcase
      if (w_ld_info) r_rinfo <= r_info[r_rd_ptr];
      if (wr_done && !wr_allow) r_ovf_err <= 1'b1;
    end
  end

`ifdef BF_PARA_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (wr_done && !wr_allow && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  bf_para_lat_pipe #(
    .DEPTH (RD_LAT),
    .W     (2)
  ) u_lat_pipe (
    .i_clk (clk),
    .i_rst (rst),
    .i_dat ({w_rden, w_last}),
    .o_dat (w_pipe_out)
  );

  // Stride is a power of two and word_cnt < stride, so the shift-add is exact.
  assign bit_raddr = (RADDR_W'(r_rd_ptr) << $clog2(SLOT_STRIDE)) + RADDR_W'(r_word_cnt);
  assign ram_rden  = w_rden;
  assign bit_rvld  = w_pipe_out[1];
  assign bit_rlast = w_pipe_out[0];
  assign bit_rinfo = r_rinfo;
  assign wr_slot   = r_wr_ptr;
  assign free_size = r_free;
  assign ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_bf_para_rd_sched.sv
// Directed self-checking bench for bf_para_rd_sched; checks ovf_cnt when BF_PARA_OVF_CNT_EN is defined.
module tb_bf_para_rd_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_done = 1'b0;
  logic [23:0] wr_info = '0;
  logic        bit_rrdy = 1'b0;
  logic [1:0]  wr_slot;
  logic        wr_allow;
  logic [16:0] bit_raddr;
  logic        ram_rden;
  logic        bit_rvld;
  logic [23:0] bit_rinfo;
  logic        bit_rlast;
  logic [2:0]  free_size;
  logic        ovf_err;
`ifdef BF_PARA_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  bf_para_rd_sched dut (
    .clk       (clk),
    .rst       (rst),
    .wr_done   (wr_done),
    .wr_info   (wr_info),
    .wr_slot   (wr_slot),
    .wr_allow  (wr_allow),
    .bit_rrdy  (bit_rrdy),
    .bit_raddr (bit_raddr),
    .ram_rden  (ram_rden),
    .bit_rvld  (bit_rvld),
    .bit_rinfo (bit_rinfo),
    .bit_rlast (bit_rlast),
    .free_size (free_size),
`ifdef BF_PARA_OVF_CNT_EN
    .ovf_cnt   (ovf_cnt),
`endif
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int addr_q[$];
  int rden_cyc_q[$];
  int rvld_cyc_q[$];
  int rlast_cyc_q[$];
  logic [23:0] rinfo_q[$];
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ram_rden === 1'b1) begin
      addr_q.push_back(int'(bit_raddr));
      rden_cyc_q.push_back(cyc);
    end
    if (bit_rvld === 1'b1) begin
      rvld_cyc_q.push_back(cyc);
      rinfo_q.push_back(bit_rinfo);
    end
    if (bit_rlast === 1'b1) rlast_cyc_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_done = 1'b0;
    wr_info = '0;
    bit_rrdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_wr(input logic [23:0] info);
    step();
    wr_done = 1'b1;
    wr_info = info;
    step();
    wr_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (free_size !== 3'd4) begin failures++; $display("FAIL reset_free_size got=%0d exp=4", free_size); end
    checks++; if (wr_allow !== 1'b1) begin failures++; $display("FAIL reset_wr_allow got=%b exp=1", wr_allow); end
    checks++; if (wr_slot !== 2'd0) begin failures++; $display("FAIL reset_wr_slot got=%0d exp=0", wr_slot); end
    checks++; if (ram_rden !== 1'b0) begin failures++; $display("FAIL reset_ram_rden got=%b exp=0", ram_rden); end
    checks++; if (bit_rvld !== 1'b0) begin failures++; $display("FAIL reset_rvld got=%b exp=0", bit_rvld); end
    checks++; if (bit_rlast !== 1'b0) begin failures++; $display("FAIL reset_rlast got=%b exp=0", bit_rlast); end
    checks++; if (bit_raddr !== 17'd0) begin failures++; $display("FAIL reset_raddr got=%0d exp=0", bit_raddr); end
    checks++; if (bit_rinfo !== 24'd0) begin failures++; $display("FAIL reset_rinfo got=%h exp=0", bit_rinfo); end
    checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf_err got=%b exp=0", ovf_err); end
  endtask

  task automatic test_single_frame();
    int ba, bv, bl, e;
    ba = addr_q.size(); bv = rvld_cyc_q.size(); bl = rlast_cyc_q.size();
    bit_rrdy = 1'b1;
    pulse_wr(24'hA5A5A5);
    @(negedge clk);
    checks++; if (free_size !== 3'd3) begin failures++; $display("FAIL single_free_busy got=%0d exp=3", free_size); end
    for (int k = 0; k < 400; k++) begin
      if (rvld_cyc_q.size() - bv >= 80 && free_size === 3'd4) break;
      step();
    end
    checks++; if (free_size !== 3'd4) begin failures++; $display("FAIL single_free_after got=%0d exp=4", free_size); end
    checks++; if (addr_q.size() - ba != 80) begin failures++; $display("FAIL single_rden_cnt got=%0d exp=80", addr_q.size() - ba); end
    checks++; if (rvld_cyc_q.size() - bv != 80) begin failures++; $display("FAIL single_rvld_cnt got=%0d exp=80", rvld_cyc_q.size() - bv); end
    checks++; if (rlast_cyc_q.size() - bl != 1) begin failures++; $display("FAIL single_rlast_cnt got=%0d exp=1", rlast_cyc_q.size() - bl); end
    if (addr_q.size() - ba >= 80 && rvld_cyc_q.size() - bv >= 80 && rlast_cyc_q.size() - bl >= 1) begin
      e = 0;
      for (int i = 0; i < 80; i++) if (addr_q[ba+i] != i) e++;
      checks++; if (e != 0) begin failures++; $display("FAIL single_addr_seq got=%0d_bad exp=0_bad", e); end
      checks++; if (rden_cyc_q[ba+79] - rden_cyc_q[ba] != 79) begin failures++; $display("FAIL single_addr_span got=%0d exp=79", rden_cyc_q[ba+79] - rden_cyc_q[ba]); end
      checks++; if (rvld_cyc_q[bv] - rden_cyc_q[ba] != 3) begin failures++; $display("FAIL single_rd_lat got=%0d exp=3", rvld_cyc_q[bv] - rden_cyc_q[ba]); end
      checks++; if (rlast_cyc_q[bl] != rvld_cyc_q[bv+79]) begin failures++; $display("FAIL single_rlast_pos got=%0d exp=%0d", rlast_cyc_q[bl], rvld_cyc_q[bv+79]); end
      e = 0;
      for (int i = 0; i < 80; i++) if (rinfo_q[bv+i] !== 24'hA5A5A5) e++;
      checks++; if (e != 0) begin failures++; $display("FAIL single_rinfo got=%0d_bad exp=0_bad", e); end
    end
  endtask

  task automatic test_overflow_back_to_back();
    logic [23:0] info_tbl [5];
    int ba, bv, bl, e;
    info_tbl[0] = 24'h111111; info_tbl[1] = 24'h222222; info_tbl[2] = 24'h333333;
    info_tbl[3] = 24'h444444; info_tbl[4] = 24'h555555;
    do_reset();
    ba = addr_q.size(); bv = rvld_cyc_q.size(); bl = rlast_cyc_q.size();
    e = 0;
    for (int i = 0; i < 4; i++) begin
      pulse_wr(info_tbl[i]);
      @(negedge clk);
      if (wr_slot !== 2'((i + 1) % 4)) e++;
    end
    checks++; if (e != 0) begin failures++; $display("FAIL ovf_wr_slot_seq got=%0d_bad exp=0_bad", e); end
    checks++; if (free_size !== 3'd0) begin failures++; $display("FAIL ovf_free_full got=%0d exp=0", free_size); end
    checks++; if (wr_allow !== 1'b0) begin failures++; $display("FAIL ovf_wr_allow got=%b exp=0", wr_allow); end
    checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_err_early got=%b exp=0", ovf_err); end
    pulse_wr(24'hDEAD00);
    @(negedge clk);
    checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_err_set got=%b exp=1", ovf_err); end
    checks++; if (wr_slot !== 2'd0) begin failures++; $display("FAIL ovf_wr_slot_hold got=%0d exp=0", wr_slot); end
    checks++; if (free_size !== 3'd0) begin failures++; $display("FAIL ovf_free_hold got=%0d exp=0", free_size); end
`ifdef BF_PARA_OVF_CNT_EN
    checks++; if (ovf_cnt !== 16'd1) begin failures++; $display("FAIL ovf_cnt got=%0d exp=1", ovf_cnt); end
`endif
    step();
    bit_rrdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (free_size === 3'd1) break;
      step();
    end
    checks++; if (free_size !== 3'd1) begin failures++; $display("FAIL b2b_first_release got=%0d exp=1", free_size); end
    pulse_wr(info_tbl[4]);
    for (int k = 0; k < 1000; k++) begin
      if (rvld_cyc_q.size() - bv >= 400 && free_size === 3'd4) break;
      step();
    end
    checks++; if (addr_q.size() - ba != 400) begin failures++; $display("FAIL b2b_rden_cnt got=%0d exp=400", addr_q.size() - ba); end
    checks++; if (rlast_cyc_q.size() - bl != 5) begin failures++; $display("FAIL b2b_rlast_cnt got=%0d exp=5", rlast_cyc_q.size() - bl); end
    checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL b2b_ovf_sticky got=%b exp=1", ovf_err); end
    if (addr_q.size() - ba >= 400 && rvld_cyc_q.size() - bv >= 400) begin
      e = 0;
      for (int j = 0; j < 400; j++) if (addr_q[ba+j] != ((j / 80) % 4) * 128 + (j % 80)) e++;
      checks++; if (e != 0) begin failures++; $display("FAIL b2b_addr_seq got=%0d_bad exp=0_bad", e); end
      e = 0;
      for (int j = 0; j < 400; j++) if (rinfo_q[bv+j] !== info_tbl[j / 80]) e++;
      checks++; if (e != 0) begin failures++; $display("FAIL b2b_rinfo_seq got=%0d_bad exp=0_bad", e); end
      checks++; if (rden_cyc_q[ba+80] - rden_cyc_q[ba+79] != 5) begin failures++; $display("FAIL b2b_frame_gap got=%0d exp=5", rden_cyc_q[ba+80] - rden_cyc_q[ba+79]); end
      checks++; if (addr_q[ba+320] != 0) begin failures++; $display("FAIL b2b_wrap_addr got=%0d exp=0", addr_q[ba+320]); end
    end
  endtask

  task automatic test_rrdy_toggle();
    int ba, bv, e;
    do_reset();
    bit_rrdy = 1'b1;
    pulse_wr(24'h000001);
    pulse_wr(24'h000002);
    for (int k = 0; k < 500; k++) begin
      if (free_size === 3'd4) break;
      step();
    end
    checks++; if (free_size !== 3'd4) begin failures++; $display("FAIL tog_preload_drain got=%0d exp=4", free_size); end
    bit_rrdy = 1'b0;
    ba = addr_q.size(); bv = rvld_cyc_q.size();
    pulse_wr(24'hC3C3C3);
    for (int k = 0; k < 600; k++) begin
      if (rvld_cyc_q.size() - bv >= 80 && free_size === 3'd4) break;
      bit_rrdy = ~bit_rrdy;
      step();
    end
    checks++; if (addr_q.size() - ba != 80) begin failures++; $display("FAIL tog_rden_cnt got=%0d exp=80", addr_q.size() - ba); end
    checks++; if (rvld_cyc_q.size() - bv != 80) begin failures++; $display("FAIL tog_rvld_cnt got=%0d exp=80", rvld_cyc_q.size() - bv); end
    if (addr_q.size() - ba >= 80 && rvld_cyc_q.size() - bv >= 80) begin
      e = 0;
      for (int i = 0; i < 80; i++) if (addr_q[ba+i] != 256 + i) e++;
      checks++; if (e != 0) begin failures++; $display("FAIL tog_addr_seq got=%0d_bad exp=0_bad", e); end
      checks++; if (rden_cyc_q[ba+79] - rden_cyc_q[ba] != 158) begin failures++; $display("FAIL tog_span got=%0d exp=158", rden_cyc_q[ba+79] - rden_cyc_q[ba]); end
      e = 0;
      for (int i = 0; i < 80; i++) if (rvld_cyc_q[bv+i] != rden_cyc_q[ba+i] + 3) e++;
      checks++; if (e != 0) begin failures++; $display("FAIL tog_rvld_mirror got=%0d_bad exp=0_bad", e); end
      checks++; if (rinfo_q[bv+40] !== 24'hC3C3C3) begin failures++; $display("FAIL tog_rinfo got=%h exp=c3c3c3", rinfo_q[bv+40]); end
    end
  endtask

  task automatic test_coincident_release();
    int ba, bv;
    do_reset();
    ba = addr_q.size(); bv = rvld_cyc_q.size();
    pulse_wr(24'hAAAA01);
    pulse_wr(24'hAAAA02);
    @(negedge clk);
    checks++; if (free_size !== 3'd2) begin failures++; $display("FAIL coin_free_pre got=%0d exp=2", free_size); end
    step();
    bit_rrdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (bit_rlast === 1'b1) break;
      step();
    end
    checks++; if (bit_rlast !== 1'b1) begin failures++; $display("FAIL coin_find_release got=%b exp=1", bit_rlast); end
    wr_done = 1'b1;
    wr_info = 24'hAAAA03;
    step();
    wr_done = 1'b0;
    @(negedge clk);
    checks++; if (free_size !== 3'd2) begin failures++; $display("FAIL coin_free_hold got=%0d exp=2", free_size); end
    checks++; if (wr_slot !== 2'd3) begin failures++; $display("FAIL coin_wr_slot got=%0d exp=3", wr_slot); end
    for (int k = 0; k < 800; k++) begin
      if (rvld_cyc_q.size() - bv >= 240 && free_size === 3'd4) break;
      step();
    end
    checks++; if (addr_q.size() - ba != 240) begin failures++; $display("FAIL coin_rden_cnt got=%0d exp=240", addr_q.size() - ba); end
    if (addr_q.size() - ba >= 240 && rvld_cyc_q.size() - bv >= 240) begin
      checks++; if (addr_q[ba+80] != 128) begin failures++; $display("FAIL coin_rd_ptr_adv got=%0d exp=128", addr_q[ba+80]); end
      checks++; if (addr_q[ba+160] != 256) begin failures++; $display("FAIL coin_third_slot got=%0d exp=256", addr_q[ba+160]); end
      checks++; if (rinfo_q[bv+160] !== 24'hAAAA03) begin failures++; $display("FAIL coin_third_info got=%h exp=aaaa03", rinfo_q[bv+160]); end
    end
  endtask

  task automatic test_rst_midburst();
    int ba, nv, na, e;
    do_reset();
    bit_rrdy = 1'b1;
    ba = addr_q.size();
    pulse_wr(24'h777777);
    for (int k = 0; k < 300; k++) begin
      if (addr_q.size() - ba >= 40) break;
      step();
    end
    checks++; if (bit_rvld !== 1'b1) begin failures++; $display("FAIL rstm_burst_active got=%b exp=1", bit_rvld); end
    rst = 1'b1;
    #1;
    checks++; if (ram_rden !== 1'b0) begin failures++; $display("FAIL rstm_rden got=%b exp=0", ram_rden); end
    checks++; if (bit_rvld !== 1'b0) begin failures++; $display("FAIL rstm_rvld got=%b exp=0", bit_rvld); end
    checks++; if (bit_raddr !== 17'd0) begin failures++; $display("FAIL rstm_raddr got=%0d exp=0", bit_raddr); end
    checks++; if (free_size !== 3'd4) begin failures++; $display("FAIL rstm_free got=%0d exp=4", free_size); end
    checks++; if (bit_rinfo !== 24'd0) begin failures++; $display("FAIL rstm_rinfo got=%h exp=0", bit_rinfo); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nv = rvld_cyc_q.size();
    na = addr_q.size();
    repeat (10) step();
    checks++; if (rvld_cyc_q.size() != nv) begin failures++; $display("FAIL rstm_stale_rvld got=%0d exp=0", rvld_cyc_q.size() - nv); end
    checks++; if (addr_q.size() != na) begin failures++; $display("FAIL rstm_stale_rden got=%0d exp=0", addr_q.size() - na); end
    pulse_wr(24'h888888);
    for (int k = 0; k < 400; k++) begin
      if (rvld_cyc_q.size() - nv >= 80 && free_size === 3'd4) break;
      step();
    end
    checks++; if (addr_q.size() - na != 80) begin failures++; $display("FAIL rstm_next_cnt got=%0d exp=80", addr_q.size() - na); end
    if (addr_q.size() - na >= 80) begin
      e = 0;
      for (int i = 0; i < 80; i++) if (addr_q[na+i] != i) e++;
      checks++; if (e != 0) begin failures++; $display("FAIL rstm_next_addr got=%0d_bad exp=0_bad", e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow_back_to_back();
    test_rrdy_toggle();
    test_coincident_release();
    test_rst_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
